// File: rtl/hub75_scan_driver_if.sv
// Bus bundle between the HUB75 scan driver and its surroundings.
//   RdAddr : frame-buffer read address {row[2:0], col}
//   RdData : frame-buffer read data {R1,G1,B1,R2,G2,B2}, valid one cycle after RdAddr
//   R1..B2 : panel colour data (upper / lower half)
//   Clk    : panel shift clock (panel samples on rising edge)
//   Lat    : latch strobe, active high
//   Oe     : output enable, active low
//   A,B,C  : row-pair address, A = LSB
// master = scan driver, slave = frame buffer / panel pins.
interface hub75_scan_driver_if #(
   parameter int COL_BITS = 5
);
   logic [COL_BITS+2:0] RdAddr;
   logic [5:0]          RdData;
   logic                R1, G1, B1, R2, G2, B2;
   logic                Clk;
   logic                Lat;
   logic                Oe;
   logic                A, B, C;

   modport master (
      output RdAddr,
      input  RdData,
      output R1, G1, B1, R2, G2, B2,
      output Clk, Lat, Oe, A, B, C
   );

   modport slave (
      input  RdAddr,
      output RdData,
      input  R1, G1, B1, R2, G2, B2,
      input  Clk, Lat, Oe, A, B, C
   );
endinterface

// File: rtl/hub75_scan_driver.sv
// HUB75 1/8-scan panel driver.
// Reads pixel pairs from an external frame buffer, shifts one row pair into
// the panel per row period, latches it and scans the 8 row pairs forever
// while Enable is high.
// Ports:
//   Clkin     : system clock
//   Rstn      : asynchronous active-low reset
//   Enable    : run the scan when high (checked at the end of each row)
//   bus       : frame-buffer read bus and panel outputs (master side)
//   FrameDone : one-cycle pulse in the display-hold phase of row 7
// Every panel output is a flop driven from the state of the previous cycle,
// so all outputs lag the internal state by exactly one Clkin cycle.
module hub75_scan_driver #(
   parameter int CLK_DIV  = 3,
   parameter int COL_BITS = 5,
   parameter int ON_TICKS = 4
) (
   input  logic                      Clkin,
   input  logic                      Rstn,
   input  logic                      Enable,
   hub75_scan_driver_if.master       bus,
   output logic                      FrameDone
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      BLANK    = 3'd3,
      LATCH    = 3'd4,
      POST     = 3'd5,
      HOLD     = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [7:0]            hold_q, hold_d;
   logic [COL_BITS-1:0]   col_q, col_d;
   logic [2:0]            row_q, row_d;
   logic                  first_q, first_d;
   logic [COL_BITS+2:0]   rd_addr_q, rd_addr_d;
   logic [5:0]            rgb_q, rgb_d;
   logic                  clk_q, clk_d;
   logic                  lat_q, lat_d;
   logic                  oe_q, oe_d;
   logic [2:0]            abc_q, abc_d;
   logic                  frame_done_q, frame_done_d;
   logic                  tick_s;
   logic                  row_end_s;

   // Next-state, prescaler, counters and registered-output values.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      col_d     = col_q;
      row_d     = row_q;
      first_d   = first_q;
      row_end_s = 1'b0;
      tick_s    = (cnt_q == 8'(CLK_DIV - 1));

      // Prescaler sits at zero in IDLE, so it always starts cleared on exit.
      if (state_q == IDLE) begin
         cnt_d = 8'd0;
      end else if (tick_s) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (Enable) begin
               state_d = SHIFT_LO;
               col_d   = {COL_BITS{1'b0}};
               first_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT_LO: begin
            if (tick_s) begin
               state_d = SHIFT_HI;
            end else begin
               state_d = SHIFT_LO;
            end
         end
         SHIFT_HI: begin
            if (tick_s && (col_q == {COL_BITS{1'b1}})) begin
               state_d = BLANK;
            end else if (tick_s) begin
               col_d   = col_q + {{(COL_BITS-1){1'b0}}, 1'b1};
               state_d = SHIFT_LO;
            end else begin
               state_d = SHIFT_HI;
            end
         end
         BLANK: begin
            if (tick_s) begin
               state_d = LATCH;
            end else begin
               state_d = BLANK;
            end
         end
         LATCH: begin
            if (tick_s) begin
               state_d = POST;
            end else begin
               state_d = LATCH;
            end
         end
         POST: begin
            if (tick_s && (ON_TICKS > 0)) begin
               state_d = HOLD;
               hold_d  = 8'd0;
            end else if (tick_s) begin
               row_end_s = 1'b1;   // no hold phase configured
            end else begin
               state_d = POST;
            end
         end
         HOLD: begin
            if (tick_s && (hold_q == 8'(ON_TICKS - 1))) begin
               row_end_s = 1'b1;
            end else if (tick_s) begin
               hold_d = hold_q + 8'd1;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Enable is only honoured at a row boundary; the row counter advances
      // even when stopping, so a restart continues with the next row.
      if (row_end_s) begin
         row_d   = row_q + 3'd1;
         col_d   = {COL_BITS{1'b0}};
         first_d = 1'b0;
         if (Enable) begin
            state_d = SHIFT_LO;
         end else begin
            state_d = IDLE;
         end
      end else begin
         row_d = row_q;
      end

      // Address is presented on SHIFT_LO entry so the data is back in time
      // to be captured in the second SHIFT_LO cycle (works down to D = 2).
      if ((state_d == SHIFT_LO) && (state_q != SHIFT_LO)) begin
         rd_addr_d = {row_d, col_d};
      end else begin
         rd_addr_d = rd_addr_q;
      end

      if ((state_q == SHIFT_LO) && (cnt_q == 8'd1)) begin
         rgb_d = bus.RdData;
      end else begin
         rgb_d = rgb_q;
      end

      if ((state_q == LATCH) && (cnt_q == 8'd0)) begin
         abc_d = row_q;
      end else begin
         abc_d = abc_q;
      end

      // Display stays on while shifting (old row still latched), except for
      // the first row after IDLE where nothing valid has been latched yet.
      if (state_q == HOLD) begin
         oe_d = 1'b0;
      end else if (((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && !first_q) begin
         oe_d = 1'b0;
      end else begin
         oe_d = 1'b1;
      end

      clk_d        = (state_q == SHIFT_HI);
      lat_d        = (state_q == LATCH);
      frame_done_d = (state_q == POST) && tick_s && (row_q == 3'd7);
   end

   // State and output registers.
   always_ff @(posedge Clkin or negedge Rstn) begin
      if (!Rstn) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         hold_q       <= 8'd0;
         col_q        <= {COL_BITS{1'b0}};
         row_q        <= 3'd0;
         first_q      <= 1'b0;
         rd_addr_q    <= {(COL_BITS+3){1'b0}};
         rgb_q        <= 6'd0;
         clk_q        <= 1'b0;
         lat_q        <= 1'b0;
         oe_q         <= 1'b1;
         abc_q        <= 3'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         col_q        <= col_d;
         row_q        <= row_d;
         first_q      <= first_d;
         rd_addr_q    <= rd_addr_d;
         rgb_q        <= rgb_d;
         clk_q        <= clk_d;
         lat_q        <= lat_d;
         oe_q         <= oe_d;
         abc_q        <= abc_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.RdAddr = rd_addr_q;
   assign bus.R1     = rgb_q[5];
   assign bus.G1     = rgb_q[4];
   assign bus.B1     = rgb_q[3];
   assign bus.R2     = rgb_q[2];
   assign bus.G2     = rgb_q[1];
   assign bus.B2     = rgb_q[0];
   assign bus.Clk    = clk_q;
   assign bus.Lat    = lat_q;
   assign bus.Oe     = oe_q;
   assign bus.A      = abc_q[0];
   assign bus.B      = abc_q[1];
   assign bus.C      = abc_q[2];
   assign FrameDone  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: default configuration (D=3, ON_TICKS=4)
// plus a second instance with D=2, ON_TICKS=0. A negedge monitor on the
// selected instance gathers edge counts, periods and latched addresses.
module tb_hub75_scan_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   logic enable = 1'b1;
   logic fd1, fd2;
   logic sel = 1'b0;
   logic pat = 1'b0;
   logic row_chk = 1'b0;
   logic mon_clr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   hub75_scan_driver_if #(.COL_BITS(5)) bus1 ();
   hub75_scan_driver_if #(.COL_BITS(5)) bus2 ();

   hub75_scan_driver #(.CLK_DIV(3), .COL_BITS(5), .ON_TICKS(4)) dut1 (
      .Clkin(clk), .Rstn(rst_n), .Enable(enable), .bus(bus1), .FrameDone(fd1));

   hub75_scan_driver #(.CLK_DIV(2), .COL_BITS(5), .ON_TICKS(0)) dut2 (
      .Clkin(clk), .Rstn(rst2_n), .Enable(enable), .bus(bus2), .FrameDone(fd2));

   always #5 clk = ~clk;

   // Frame-buffer model: one-cycle read latency.
   // pat=0: every colour bit = col[0]; pat=1: {row,row}.
   always @(posedge clk) begin
      bus1.RdData <= pat ? {2{bus1.RdAddr[7:5]}} : {6{bus1.RdAddr[0]}};
      bus2.RdData <= pat ? {2{bus2.RdAddr[7:5]}} : {6{bus2.RdAddr[0]}};
   end

   logic       m_clk, m_lat, m_oe, m_fd;
   logic [2:0] m_abc;
   logic [5:0] m_rgb;
   assign m_clk = sel ? bus2.Clk : bus1.Clk;
   assign m_lat = sel ? bus2.Lat : bus1.Lat;
   assign m_oe  = sel ? bus2.Oe  : bus1.Oe;
   assign m_fd  = sel ? fd2 : fd1;
   assign m_abc = sel ? {bus2.C, bus2.B, bus2.A} : {bus1.C, bus1.B, bus1.A};
   assign m_rgb = sel ? {bus2.R1, bus2.G1, bus2.B1, bus2.R2, bus2.G2, bus2.B2}
                      : {bus1.R1, bus1.G1, bus1.B1, bus1.R2, bus1.G2, bus1.B2};

   int cyc, last_lat_cyc, period, rise_since_lat, rises_last, lat_cnt, lat_hi, lat_len;
   int uniform_bad, stable_viol, overlap, abc_viol, fd_cnt, fd_long, row_viol;
   logic [31:0] bits;
   logic [5:0]  last_rgb, prev_rgb;
   logic [2:0]  prev_abc;
   logic        prev_clk, prev_lat, prev_oe, prev_fd;
   logic [2:0]  abc_log [0:63];

   // Observation monitor on the selected instance.
   always @(negedge clk) begin
      if (mon_clr) begin
         cyc <= 0; last_lat_cyc <= 0; period <= 0; rise_since_lat <= 0; rises_last <= 0;
         lat_cnt <= 0; lat_hi <= 0; lat_len <= 0; uniform_bad <= 0; stable_viol <= 0;
         overlap <= 0; abc_viol <= 0; fd_cnt <= 0; fd_long <= 0; row_viol <= 0;
         bits <= 32'd0; last_rgb <= 6'd0;
         prev_clk <= m_clk; prev_lat <= m_lat; prev_oe <= m_oe; prev_fd <= m_fd;
         prev_abc <= m_abc; prev_rgb <= m_rgb;
      end else begin
         cyc <= cyc + 1;
         if (m_clk && !prev_clk) begin
            if (!pat) begin
               bits[rise_since_lat[4:0]] <= m_rgb[5];
               if (m_rgb != 6'h00 && m_rgb != 6'h3f) uniform_bad <= uniform_bad + 1;
            end
            if (m_rgb != prev_rgb) stable_viol <= stable_viol + 1;
            last_rgb <= m_rgb;
         end
         if (m_lat && !prev_lat) begin
            if (lat_cnt < 64) abc_log[lat_cnt] <= m_abc;
            if (row_chk && last_rgb != {m_abc, m_abc}) row_viol <= row_viol + 1;
            period         <= cyc - last_lat_cyc;
            last_lat_cyc   <= cyc;
            rises_last     <= rise_since_lat;
            rise_since_lat <= 0;
            lat_cnt        <= lat_cnt + 1;
         end else if (m_clk && !prev_clk) begin
            rise_since_lat <= rise_since_lat + 1;
         end
         if (m_lat && m_clk) overlap <= overlap + 1;
         if (m_lat) begin
            lat_hi <= lat_hi + 1;
         end else if (prev_lat) begin
            lat_len <= lat_hi;
            lat_hi  <= 0;
         end
         if (m_fd) fd_cnt <= fd_cnt + 1;
         if (m_fd && prev_fd) fd_long <= fd_long + 1;
         if (m_abc != prev_abc && (!m_oe || !prev_oe)) abc_viol <= abc_viol + 1;
         prev_clk <= m_clk; prev_lat <= m_lat; prev_oe <= m_oe; prev_fd <= m_fd;
         prev_abc <= m_abc; prev_rgb <= m_rgb;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_lat(input int n, input int budget);
      int g = 0;
      while (lat_cnt < n && g < budget) begin
         @(negedge clk); #1;
         g++;
      end
      chk("lat_reached", 32'(lat_cnt >= n), 32'd1);
   endtask

   task automatic wait_rises(input int n, input int budget);
      int g = 0;
      while (rise_since_lat < n && g < budget) begin
         @(negedge clk); #1;
         g++;
      end
      chk("rises_reached", 32'(rise_since_lat >= n), 32'd1);
   endtask

   task automatic clear_mon();
      @(negedge clk); #1; mon_clr = 1'b1;
      @(negedge clk); #1; mon_clr = 1'b0;
   endtask

   initial begin
      int n;
      int bad;
      // Reset held with Enable high: only Oe is 1.
      repeat (4) @(negedge clk);
      #1;
      chk("reset_outs", {bus1.Oe, bus1.Clk, bus1.Lat, bus1.C, bus1.B, bus1.A,
                         bus1.R1, bus1.G1, bus1.B1, bus1.R2, bus1.G2, bus1.B2, fd1},
          {1'b1, 12'd0});
      chk("reset_rdaddr", 32'(bus1.RdAddr), 32'd0);
      mon_clr = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;

      // Release: edge 1 leaves IDLE, Clk rises 4 edges after SHIFT_LO start.
      rst_n = 1'b1;
      n = 0;
      while (!bus1.Clk && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("first_clk_rise_edges", 32'(n), 32'd5);

      // Row 0 / row 1 with the col[0] pattern.
      wait_lat(1, 400);
      chk("row0_abc", 32'(abc_log[0]), 32'd0);
      chk("row0_rises", 32'(rises_last), 32'd32);
      chk("row0_bits", bits, 32'hAAAAAAAA);
      wait_lat(2, 400);
      chk("row_period", 32'(period), 32'd213);
      chk("lat_len", 32'(lat_len), 32'd3);
      chk("colour_uniform", 32'(uniform_bad), 32'd0);
      pat = 1'b1;
      row_chk = 1'b1;

      // Full frame and beyond.
      wait_lat(11, 3000);
      bad = 0;
      for (int i = 0; i < 11; i++) if (abc_log[i] != 3'(i % 8)) bad++;
      chk("abc_sequence", 32'(bad), 32'd0);
      chk("framedone_once", 32'(fd_cnt), 32'd1);
      wait_lat(17, 2000);
      chk("abc_wrap", 32'(abc_log[16]), 32'd0);
      chk("framedone_twice", 32'(fd_cnt), 32'd2);
      chk("framedone_width", 32'(fd_long), 32'd0);
      chk("row_field", 32'(row_viol), 32'd0);
      chk("lat_clk_overlap", 32'(overlap), 32'd0);
      chk("abc_while_on", 32'(abc_viol), 32'd0);

      // Drop Enable at column 10 of row 2.
      wait_lat(18, 400);
      wait_rises(10, 200);
      enable = 1'b0;
      repeat (400) @(negedge clk);
      #1;
      chk("stop_lat_count", 32'(lat_cnt), 32'd19);
      chk("stop_row_abc", 32'(abc_log[18]), 32'd2);
      chk("stop_row_rises", 32'(rises_last), 32'd32);
      chk("idle_no_shift", 32'(rise_since_lat), 32'd0);
      chk("idle_oe_clk", {bus1.Oe, bus1.Clk}, 2'b10);
      enable = 1'b1;
      wait_lat(20, 400);
      chk("restart_next_row", 32'(abc_log[19]), 32'd3);

      // Asynchronous reset during SHIFT_HI of column 5.
      wait_rises(6, 200);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", {bus1.Oe, bus1.Clk, bus1.Lat, bus1.C, bus1.B, bus1.A,
                               bus1.R1, bus1.G1, bus1.B1, bus1.R2, bus1.G2, bus1.B2, fd1},
          {1'b1, 12'd0});
      chk("async_reset_rdaddr", 32'(bus1.RdAddr), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      mon_clr = 1'b1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
      wait_lat(1, 400);
      chk("post_reset_row", 32'(abc_log[0]), 32'd0);
      chk("post_reset_rises", 32'(rises_last), 32'd32);
      chk("post_reset_data", 32'(row_viol), 32'd0);

      // Second configuration: D = 2, no hold phase.
      sel = 1'b1;
      clear_mon();
      rst2_n = 1'b1;
      wait_lat(3, 1000);
      chk("d2_period", 32'(period), 32'd134);
      chk("d2_rises", 32'(rises_last), 32'd32);
      chk("d2_lat_len", 32'(lat_len), 32'd2);
      chk("d2_data_setup", 32'(stable_viol), 32'd0);
      chk("d2_abc", {abc_log[0], abc_log[1], abc_log[2]}, {3'd0, 3'd1, 3'd2});
      chk("d2_row_field", 32'(row_viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
